// File: rtl/divider_ratio_detector.sv
// Measures the period of a divided clock (div_in) in clk cycles, reports lock and mismatch, and flags a timeout.
// Optional duty-cycle checking is compiled in when DUTY_CHECK_EN is defined.
module divider_ratio_detector #(
    parameter int CNT_W    = 4,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             div_in,
    input  logic [CNT_W-1:0] expected_ratio,
    output logic [CNT_W-1:0] ratio,
    output logic             ratio_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             timeout,
    output logic             duty_err
);

    localparam int LC_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [LC_W-1:0]  LOCK_VAL = LC_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        LOCK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, sync3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LC_W-1:0]  lockCnt_q, lockCnt_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic             ratioValid_q, ratioValid_d;
    logic             locked_q, locked_d;
    logic             mismatch_q, mismatch_d;
    logic             timeout_q, timeout_d;
    logic             rise;

    // div_in is asynchronous: two flops for metastability, a third for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= div_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise = sync2_q & ~sync3_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lockCnt_q    <= '0;
            ratio_q      <= '0;
            ratioValid_q <= 1'b0;
            locked_q     <= 1'b0;
            mismatch_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lockCnt_q    <= lockCnt_d;
            ratio_q      <= ratio_d;
            ratioValid_q <= ratioValid_d;
            locked_q     <= locked_d;
            mismatch_q   <= mismatch_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lockCnt_d    = lockCnt_q;
        ratio_d      = ratio_q;
        ratioValid_d = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;

        if (!enable) begin
            state_d   = IDLE;
            cnt_d     = '0;
            lockCnt_d = '0;
            ratio_d   = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                end
                default: begin
                    if (rise) begin
                        // A rise coinciding with the timeout count still counts as a valid period.
                        cnt_d     = CNT_W'(1);
                        timeout_d = 1'b0;
                        if (state_q == ARM) begin
                            state_d   = MEAS;
                            lockCnt_d = '0;
                        end else begin
                            ratio_d      = cnt_q;
                            ratioValid_d = 1'b1;
                            if ((lockCnt_q != '0) && (cnt_q == ratio_q)) begin
                                if (lockCnt_q < LOCK_VAL) begin
                                    lockCnt_d = lockCnt_q + LC_W'(1);
                                end
                            end else begin
                                lockCnt_d = LC_W'(1);
                            end
                            if (lockCnt_d == LOCK_VAL) begin
                                state_d  = LOCK;
                                locked_d = 1'b1;
                            end else begin
                                state_d  = MEAS;
                                locked_d = 1'b0;
                            end
                        end
                    end else begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if (cnt_q == TO_VAL) begin
                            timeout_d = 1'b1;
                            locked_d  = 1'b0;
                            lockCnt_d = '0;
                            state_d   = ARM;
                        end
                    end
                end
            endcase
        end

        mismatch_d = locked_d && (expected_ratio != '0) && (ratio_d != expected_ratio);
    end

`ifdef DUTY_CHECK_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             dutyErr_q, dutyErr_d;
    logic [CNT_W:0]   periodWide, halfLo, halfHi, highWide;

    // High time is counted from the rise cycle up to the cycle before the next rise.
    always_comb begin
        periodWide = {1'b0, cnt_q};
        halfLo     = periodWide >> 1;
        halfHi     = (periodWide + (CNT_W + 1)'(1)) >> 1;
        highWide   = {1'b0, hcnt_q};
        hcnt_d     = hcnt_q;
        dutyErr_d  = dutyErr_q;

        if (!enable) begin
            hcnt_d    = '0;
            dutyErr_d = 1'b0;
        end else if (rise) begin
            hcnt_d = CNT_W'(1);
            if (((state_q == MEAS) || (state_q == LOCK)) &&
                (highWide != halfLo) && (highWide != halfHi)) begin
                dutyErr_d = 1'b1;
            end
        end else if (sync2_q && (hcnt_q != CNT_MAX)) begin
            hcnt_d = hcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q    <= '0;
            dutyErr_q <= 1'b0;
        end else begin
            hcnt_q    <= hcnt_d;
            dutyErr_q <= dutyErr_d;
        end
    end

    assign duty_err = dutyErr_q;
`else
    assign duty_err = 1'b0;
`endif

    assign ratio       = ratio_q;
    assign ratio_valid = ratioValid_q;
    assign locked      = locked_q;
    assign mismatch    = mismatch_q;
    assign timeout     = timeout_q;

endmodule
